// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one operand bit per cycle.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mul_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic             r_dz;
  logic             r_nq;
  logic             r_nr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  logic             w_sgn;
  logic             w_isdiv;
  logic             w_bz;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_dsel;
  logic [2*WIDTH-1:0] w_prod;

  // Operand decode: a zero divisor keeps the raw dividend so the
  // restoring loop itself yields quotient all-ones and remainder a.
  always_comb begin
    w_sgn   = SIGNED_EN && op[0];
    w_isdiv = op[1];
    w_bz    = w_isdiv && (b == '0);
    w_sa    = w_sgn && !w_bz && a[WIDTH-1];
    w_sb    = w_sgn && !w_bz && b[WIDTH-1];
    w_ma    = w_sa ? -a : a;
    w_mb    = w_sb ? -b : b;
  end

  // One iteration of shift-add or shift-subtract, plus product view.
  always_comb begin
    w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_acc, r_q[WIDTH-1]};
    w_ge   = (w_sh >= {1'b0, r_b});
    w_dif  = w_sh[WIDTH-1:0] - r_b;
    w_dsel = w_ge ? w_dif : w_sh[WIDTH-1:0];
    w_prod = {r_acc, r_q};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == CW'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, then sign-correct and publish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_dz   <= 1'b0;
      r_nq   <= 1'b0;
      r_nr   <= 1'b0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_div <= w_isdiv;
            r_dz  <= w_bz;
            r_nq  <= w_sa ^ w_sb;
            r_nr  <= w_sa;
            r_acc <= '0;
            r_q   <= w_isdiv ? w_ma : w_mb;
            r_b   <= w_isdiv ? w_mb : w_ma;
            r_cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_div) begin
            r_acc <= w_dsel;
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_div) begin
            r_lo  <= r_nq ? -r_q : r_q;
            r_hi  <= r_nr ? -r_acc : r_acc;
            r_dbz <= r_dz;
          end else begin
            {r_hi, r_lo} <= r_nq ? -w_prod : w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32.
// Driver queues expected results; monitor checks each done pulse.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    bit           ck;
    int           at;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic prev_done = 1'b0;

  localparam logic [1:0] MULU = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DIVU = 2'b10;
  localparam logic [1:0] DIV  = 2'b11;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
      chk("busy_low_in_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h want none", hi, lo);
      end else begin
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.at));
        if (e.ck) chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
      end
    end
    prev_done <= done;
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic ed,
                       input bit ck);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: busy still %b want 0", busy);
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e.hi = eh;
    e.lo = el;
    e.dbz = ed;
    e.ck = ck;
    e.at = cyc + W + 1;
    sb.push_back(e);
    start = 1'b0;
    a = ~x;
    b = ~y;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: pending %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    issue(MULU, 32'd6, 32'd4, 32'h0, 32'd24, 1'b0, 1'b0);
    drain();
    issue(MUL, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    issue(MULU, 32'd1, 32'd2, 32'h0, 32'd2, 1'b0, 1'b0);
    issue(MULU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 1'b0);
    issue(MULU, 32'd6, 32'd4, 32'h0, 32'd24, 1'b0, 1'b0);
    issue(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
          1'b0, 1'b0);
    issue(MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
          1'b0, 1'b0);
    issue(DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
          1'b0, 1'b1);
    issue(DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1, 1'b1);
    issue(DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b1);
    issue(DIV, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b1);
    issue(DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 1'b1);
    issue(DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b1);

    issue(MULU, 32'd100, 32'd3, 32'h0, 32'd300, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_mid_op", {63'd0, busy}, 64'd1);
    start = 1'b1;
    op = DIV;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    drain();

    issue(MULU, 32'h1234, 32'h10, 32'h0, 32'h12340, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_hi", {32'd0, hi}, 64'd0);
    chk("post_abort_lo", {32'd0, lo}, 64'd0);

    issue(MULU, 32'd12, 32'd12, 32'h0, 32'd144, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
